// File: rtl/regfile_dump_pkg.sv
// Shared types and constants for the register-file debug dump engine.
// REGFILE_DUMP_SKIP_X0_EN moves the first dumped index from x0 to x1.
package regfile_dump_pkg;

  localparam int NREGS_DEF = 32;
  localparam int XLEN_DEF  = 32;
  localparam int IDX_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

`ifdef REGFILE_DUMP_SKIP_X0_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = 5'd1;
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = 5'd0;
`endif

endpackage

// File: rtl/regfile_dump.sv
// Walks the register file through a spare read port and streams each value on valid/ready.
// Build option REGFILE_DUMP_SKIP_X0_EN: start the walk at x1 instead of x0.
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] ra,
  input  logic [XLEN-1:0]  rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREGS - 1);

  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_data;
  logic [IDX_W-1:0] r_out_idx;
  logic             r_out_last;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_idx   <= FIRST_IDX;
            r_busy  <= 1'b1;
            r_state <= ST_READ;
          end
        end
        // rd answers combinationally for ra (= r_idx) within this cycle
        ST_READ: begin
          r_out_data  <= rd;
          r_out_idx   <= r_idx;
          r_out_last  <= (r_idx == LAST_IDX);
          r_out_valid <= 1'b1;
          r_state     <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The index register drives the read port directly so ra never glitches
  assign ra        = r_idx;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
